// File: rtl/mem_responder_ws.sv
// mem_responder_ws: single-outstanding memory responder with fixed wait states.
// A request is latched in IDLE, delayed WAIT_CYCLES edges, then completed in
// RESP with a one-cycle ready pulse. Writes at or above PROT_BASE are refused
// with err. A completion cycle blocks new requests, so a held valid sees a
// back-to-back period of WAIT_CYCLES+3 cycles.
//
// state  | meaning
// IDLE   | waiting for valid; blocked while the ready pulse is high
// WAIT   | counting down the wait states of the latched request
// RESP   | completing the latched request (ready rises on exit)
module mem_responder_ws #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int WAIT_CYCLES = 2,
  parameter int PROT_BASE   = DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ready,
  output logic                  err
);

  localparam int CNT_W      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int PROT_CLAMP = (PROT_BASE > DEPTH) ? DEPTH : PROT_BASE;

  localparam logic [CNT_W-1:0]    WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_WIDTH:0] PROT_W    = (ADDR_WIDTH + 1)'(PROT_CLAMP);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];

  logic in_range;
  logic prot_hit;

  // Decode of the latched address: bounds check and write-protect window.
  always_comb begin
    in_range = ({1'b0, addr_q} < DEPTH_W);
    prot_hit = ({1'b0, addr_q} >= PROT_W);
  end

  // Next-state, request latch, completion outputs and memory update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_d   = mem_q;

    case (state_q)
      S_IDLE: begin
        // The cycle that carries the ready pulse never accepts a request.
        if (valid && !ready_q) begin
          wr_d    = wr_rd;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        if (wr_q) begin
          if (prot_hit) begin
            err_d = 1'b1;
          end else if (in_range) begin
            mem_d[addr_q] = wdata_q;
          end
        end else begin
          rdata_d = in_range ? mem_q[addr_q] : '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registers; reset clears the FSM, outputs and every memory word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder_ws.sv
// Directed bench for mem_responder_ws with WAIT_CYCLES=2, PROT_BASE=24.
module tb_mem_responder_ws;

  logic       clk;
  logic       rst;
  logic       valid;
  logic       wr_rd;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;
  logic       err;

  int total;
  int bad;

  mem_responder_ws #(
    .WIDTH(8),
    .DEPTH(32),
    .WAIT_CYCLES(2),
    .PROT_BASE(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .wr_rd(wr_rd),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accepted at the next edge E0, ready expected 3 edges later.
  task automatic txn(input string tag, input logic w, input logic [4:0] a, input logic [7:0] d,
                     input logic exp_err, input logic [7:0] exp_rdata);
    int  n;
    bit  seen;
    valid = 1'b1;
    wr_rd = w;
    addr  = a;
    wdata = d;
    tick();
    valid = 1'b0;
    chk({tag, " ready_at_E0"}, 32'(ready), 32'd0);
    n    = 0;
    seen = 0;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (ready) seen = 1;
    end
    chk({tag, " latency"}, 32'(n), 32'd3);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " rdata"}, 32'(rdata), 32'(exp_rdata));
    tick();
    chk({tag, " ready_fall"}, 32'(ready), 32'd0);
    chk({tag, " err_fall"}, 32'(err), 32'd0);
  endtask

  initial begin
    int i;
    int cyc;
    int last;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    valid = 1'b1;
    wr_rd = 1'b0;
    addr  = 5'd5;
    wdata = 8'h00;

    // Reset with a read of addr 5 already requested.
    repeat (2) begin
      tick();
      chk("reset ready", 32'(ready), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset rdata", 32'(rdata), 32'd0);
    end
    rst = 1'b0;
    txn("rd5_after_reset", 1'b0, 5'd5, 8'h00, 1'b0, 8'h00);

    // Single write then read-back.
    txn("wr3", 1'b1, 5'd3, 8'h5A, 1'b0, 8'h00);
    txn("rd3", 1'b0, 5'd3, 8'h00, 1'b0, 8'h5A);

    // Back-to-back writes with valid held high.
    valid = 1'b1;
    wr_rd = 1'b1;
    addr  = 5'd0;
    wdata = 8'h40;
    i     = 0;
    cyc   = 0;
    last  = 0;
    while (i < 32 && cyc < 400) begin
      tick();
      cyc++;
      if (ready) begin
        if (i == 0) chk("b2b first_latency", 32'(cyc), 32'd4);
        else        chk("b2b gap", 32'(cyc - last), 32'd5);
        chk("b2b err", 32'(err), (i >= 24) ? 32'd1 : 32'd0);
        last = cyc;
        i++;
        if (i < 32) begin
          addr  = 5'(i);
          wdata = 8'(i + 8'h40);
        end else begin
          valid = 1'b0;
        end
      end else begin
        chk("b2b err_idle", 32'(err), 32'd0);
      end
    end
    valid = 1'b0;
    chk("b2b completions", 32'(i), 32'd32);
    tick();
    tick();

    for (int j = 0; j < 32; j++) begin
      txn($sformatf("readback%0d", j), 1'b0, 5'(j), 8'h00, 1'b0,
          (j < 24) ? 8'(j + 8'h40) : 8'h00);
    end

    // Protected write leaves memory and rdata alone.
    txn("rd3_pre_prot", 1'b0, 5'd3, 8'h00, 1'b0, 8'h43);
    txn("wr30_prot", 1'b1, 5'd30, 8'hFF, 1'b1, 8'h43);
    txn("rd30", 1'b0, 5'd30, 8'h00, 1'b0, 8'h00);
    txn("wr23_edge", 1'b1, 5'd23, 8'hA5, 1'b0, 8'h00);
    txn("rd23", 1'b0, 5'd23, 8'h00, 1'b0, 8'hA5);

    // Reset during the wait states of a write to addr 7.
    valid = 1'b1;
    wr_rd = 1'b1;
    addr  = 5'd7;
    wdata = 8'h11;
    tick();
    valid = 1'b0;
    tick();
    chk("abort ready_wait", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("abort ready_rst", 32'(ready), 32'd0);
    chk("abort rdata_rst", 32'(rdata), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort no_ready", 32'(ready), 32'd0);
    end
    txn("rd7_after_abort", 1'b0, 5'd7, 8'h00, 1'b0, 8'h00);
    txn("rd3_cleared", 1'b0, 5'd3, 8'h00, 1'b0, 8'h00);

    // Idle period: outputs must stay put.
    txn("wr2", 1'b1, 5'd2, 8'h77, 1'b0, 8'h00);
    txn("rd2", 1'b0, 5'd2, 8'h00, 1'b0, 8'h77);
    wr_rd = 1'b1;
    addr  = 5'd2;
    wdata = 8'hEE;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle ready", 32'(ready), 32'd0);
      chk("idle err", 32'(err), 32'd0);
      chk("idle rdata", 32'(rdata), 32'h77);
    end
    txn("rd2_after_idle", 1'b0, 5'd2, 8'h00, 1'b0, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder_ws.md
MEM_RESPONDER_WS -- requirements
Module: mem_responder_ws

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response (0 legal).
REQ-005 SHALL have parameter PROT_BASE, default DEPTH, lowest write-protected address (DEPTH = no protection).
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port valid  input  1  initiator request present.
REQ-009 SHALL have port wr_rd  input  1  1 = write, 0 = read.
REQ-010 SHALL have port addr  input  ADDR_WIDTH  word address.
REQ-011 SHALL have port wdata  input  WIDTH  write data.
REQ-012 SHALL have port rdata  output  WIDTH  registered read data.
REQ-013 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  completion-with-error flag, valid only with ready.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP.
REQ-016 In IDLE with valid=1 at edge E0: latch wr_rd/addr/wdata; go to WAIT with counter = WAIT_CYCLES, or directly to RESP if WAIT_CYCLES = 0.
REQ-017 In IDLE with valid=0: remain in IDLE; ready and err stay 0.
REQ-018 In WAIT: decrement counter each edge; leave for RESP on the edge at which the counter reaches 0; valid/addr changes ignored.
REQ-019 ready SHALL rise at edge E0+WAIT_CYCLES+1 and fall on the next edge (exactly one cycle high).
REQ-020 On the edge that ready rises: write commits mem[addr]=wdata (latched values); a read loads rdata=mem[addr].
REQ-021 A write with latched addr >= PROT_BASE SHALL not modify memory and SHALL assert err together with ready.
REQ-022 err SHALL be 0 whenever ready = 0 and for all reads.
REQ-023 rdata SHALL hold its value until the next read completion; writes and protected writes leave it unchanged.
REQ-024 RESP SHALL always return to IDLE, with no request accepted on that edge; a valid held high is re-sampled at the following edge, giving a back-to-back period of WAIT_CYCLES+3 cycles.
REQ-025 Only one transaction SHALL be outstanding; no queueing.

Reset
REQ-026 With rst=1 at an edge: state=IDLE, counter=0, ready=0, err=0, rdata=0, all memory words cleared to 0.
REQ-027 rst SHALL take priority over every other event; an in-flight transaction is aborted with no memory write and no ready pulse.
REQ-028 The first request SHALL be accepted no earlier than the first edge with rst=0.

Verification (WAIT_CYCLES=2, PROT_BASE=24, WIDTH=8, DEPTH=32)
REQ-029 rst high for 2 edges, then read addr 5 -> ready=0 and err=0 during reset; read completes with rdata=0x00, err=0.
REQ-030 write addr 3 = 0x5A accepted at E0 -> ready high only during the cycle after E0+3, err=0; subsequent read addr 3 -> rdata=0x5A.
REQ-031 valid held high, 32 sequential writes addr i = i+0x40 -> ready pulses exactly 5 cycles apart; err=1 for addr 24..31 only; read-back returns i+0x40 for addr 0..23 and 0x00 for addr 24..31.
REQ-032 write addr 30 = 0xFF -> ready=1 with err=1; then read addr 30 -> rdata=0x00, err=0.
REQ-033 rst asserted during WAIT of write addr 7 = 0x11 -> no ready pulse; after reset, read addr 7 -> rdata=0x00.
REQ-034 valid=0 for 20 cycles after reset -> ready=0, err=0, rdata unchanged throughout.
